// File: rtl/ctw_pkg.sv
// Shared types and character constants for the clock text writer.
// Character codes and the digit sanitizer live here so the top and bench agree on them.
package ctw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_FULL  = 2'd1,
        WR_COLON = 2'd2
    } ctw_state_t;

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_BAD   = 8'h3F;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    function automatic logic [7:0] sanitize_digit(input logic [7:0] ch);
        return ((ch >= CH_ZERO) && (ch <= CH_NINE)) ? ch : CH_BAD;
    endfunction

endpackage

// File: rtl/ascii_stable_filter.sv
// Two-sample stability filter for the clock-stage time word.
// A word is accepted once two consecutive samples agree and differ from the last accepted one.
module ascii_stable_filter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ascii,
    output logic [31:0] latest,
    output logic        changed
);

    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] snapshot;

    assign changed = (s0 == s1) && (s0 != snapshot);
    // Lets a consumer latch the newly accepted word on the same edge the snapshot updates.
    assign latest  = changed ? s0 : snapshot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0       <= '0;
            s1       <= '0;
            snapshot <= '0;
        end else begin
            s0 <= ascii;
            s1 <= s0;
            if (changed) begin
                snapshot <= s0;
            end
        end
    end

endmodule

// File: rtl/clock_text_writer.sv
// Writes the time word as "HH:MM" into the text-mode character RAM through a ready handshake.
// Rewrites all five characters on a new time word, and only the colon on each blink toggle.
module clock_text_writer
    import ctw_pkg::*;
#(
    parameter int COLS      = 70,
    parameter int ROW       = 0,
    parameter int COL       = 0,
    parameter int ADDR_W    = 12,
    parameter int BLINK_CYC = 50_000_000,
    parameter int BLINK_EN  = 1
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [31:0]       ascii,
    input  logic              vram_ready,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ROW * COLS + COL);
    localparam int CNT_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

    ctw_state_t state;
    ctw_state_t state_next;

    logic [31:0]      latest;
    logic             changed;
    logic [CNT_W-1:0] blink_cnt;
    logic             colon_on;
    logic             colon_tick;
    logic [7:0]       colon_char;
    logic [2:0]       index;
    logic [31:0]      word_q;
    logic [7:0]       colon_q;
    logic             full_pending;
    logic             colon_pending;
    logic             start_full;
    logic             start_colon;
    logic             last_xfer;

    ascii_stable_filter u_filter (
        .clk     (CLOCK_50),
        .rst     (rst),
        .ascii   (ascii),
        .latest  (latest),
        .changed (changed)
    );

    assign colon_tick = (BLINK_EN != 0) && (blink_cnt == CNT_LAST);
    assign colon_char = colon_on ? CH_COLON : CH_SPACE;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            colon_on  <= 1'b1;
        end else if (BLINK_EN != 0) begin
            if (colon_tick) begin
                blink_cnt <= '0;
                colon_on  <= ~colon_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A freshly accepted word counts as a full request even before its pending flag lands.
    always_comb begin
        state_next  = state;
        start_full  = 1'b0;
        start_colon = 1'b0;
        last_xfer   = 1'b0;
        case (state)
            IDLE: begin
                if (full_pending || changed) begin
                    state_next = WR_FULL;
                    start_full = 1'b1;
                end else if (colon_pending) begin
                    state_next  = WR_COLON;
                    start_colon = 1'b1;
                end
            end
            WR_FULL: begin
                if (vram_ready && (index == 3'd4)) begin
                    state_next = IDLE;
                    last_xfer  = 1'b1;
                end
            end
            WR_COLON: begin
                if (vram_ready) begin
                    state_next = IDLE;
                    last_xfer  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Characters are latched at sequence start so addr/data hold still while ready is low;
    // a toggle landing on the start edge keeps colon pending, so a stale colon gets rewritten.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            index         <= '0;
            word_q        <= '0;
            colon_q       <= CH_COLON;
            full_pending  <= 1'b1;
            colon_pending <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= last_xfer;
            if (start_full) begin
                index   <= '0;
                word_q  <= latest;
                colon_q <= colon_char;
            end else if ((state == WR_FULL) && vram_ready) begin
                index <= index + 3'd1;
            end
            if (start_colon) begin
                colon_q <= colon_char;
            end
            if (start_full) begin
                full_pending <= 1'b0;
            end else if (changed) begin
                full_pending <= 1'b1;
            end
            if (colon_tick) begin
                colon_pending <= 1'b1;
            end else if (start_full || start_colon) begin
                colon_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        vram_we   = 1'b0;
        vram_addr = BASE;
        vram_data = 8'h00;
        case (state)
            WR_FULL: begin
                vram_we   = 1'b1;
                vram_addr = BASE + ADDR_W'(index);
                case (index)
                    3'd0:    vram_data = sanitize_digit(word_q[31:24]);
                    3'd1:    vram_data = sanitize_digit(word_q[23:16]);
                    3'd2:    vram_data = colon_q;
                    3'd3:    vram_data = sanitize_digit(word_q[15:8]);
                    default: vram_data = sanitize_digit(word_q[7:0]);
                endcase
            end
            WR_COLON: begin
                vram_we   = 1'b1;
                vram_addr = BASE + ADDR_W'(2);
                vram_data = colon_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_clock_text_writer.sv
// Self-checking bench for clock_text_writer: a steady-colon instance driven by directed and
// random time words, plus a fast-blink instance checked against the blink schedule.
module tb_clock_text_writer;

    localparam int COLS     = 70;
    localparam int ROW      = 1;
    localparam int COL      = 3;
    localparam int ADDR_W   = 12;
    localparam int BASE     = ROW * COLS + COL;

    logic              clk;
    logic              rst;
    logic [31:0]       ascii;
    logic              vram_ready;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_data;
    logic              busy;
    logic              done;

    logic              rst2;
    logic [31:0]       ascii2;
    logic              ready2;
    logic              we2;
    logic [ADDR_W-1:0] addr2;
    logic [7:0]        data2;
    logic              busy2;
    logic              done2;

    int checkCount = 0;
    int passCount  = 0;
    int writeCount = 0;
    int doneCount  = 0;
    int edge2      = 0;
    int colonWrites2 = 0;
    logic randomReady = 1'b0;

    logic [7:0]        ram [0:4095];
    logic              prevValid = 1'b0;
    logic              prevWe, prevReady;
    logic [ADDR_W-1:0] prevAddr;
    logic [7:0]        prevData;

    clock_text_writer #(
        .COLS(COLS), .ROW(ROW), .COL(COL), .ADDR_W(ADDR_W),
        .BLINK_CYC(50_000_000), .BLINK_EN(0)
    ) dut (
        .CLOCK_50(clk), .rst(rst), .ascii(ascii), .vram_ready(vram_ready),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
        .busy(busy), .done(done)
    );

    clock_text_writer #(
        .COLS(COLS), .ROW(0), .COL(0), .ADDR_W(ADDR_W),
        .BLINK_CYC(8), .BLINK_EN(1)
    ) dut_blink (
        .CLOCK_50(clk), .rst(rst2), .ascii(ascii2), .vram_ready(ready2),
        .vram_we(we2), .vram_addr(addr2), .vram_data(data2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] expectChar(input logic [31:0] word, input int i);
        logic [7:0] b;
        case (i)
            0: b = word[31:24];
            1: b = word[23:16];
            2: return 8'h3A;
            3: b = word[15:8];
            default: b = word[7:0];
        endcase
        return ((b >= 8'h30) && (b <= 8'h39)) ? b : 8'h3F;
    endfunction

    function automatic logic [7:0] randChar();
        if ($urandom_range(0, 3) != 0) return 8'h30 + 8'($urandom_range(0, 9));
        return 8'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (randomReady) vram_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        @(negedge clk);
        ascii = word;
    endtask

    task automatic settle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < 400) begin
            tick();
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 8) checkOutput({tag, "_settle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic checkDisplay(input string tag, input logic [31:0] word);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s_char%0d", tag, i), 32'(ram[BASE + i]), 32'(expectChar(word, i)));
        end
    endtask

    task automatic waitAddr(input int offset, input string tag);
        int n = 0;
        while (!(vram_we && (vram_addr == ADDR_W'(BASE + offset))) && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "_reached"}, 32'(vram_addr), 32'(BASE + offset));
    endtask

    // Write monitor: mirrors accepted writes into a RAM image and checks handshake hold.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (prevValid && prevWe && !prevReady && vram_we) begin
                checkOutput("hold_addr", 32'(vram_addr), 32'(prevAddr));
                checkOutput("hold_data", 32'(vram_data), 32'(prevData));
            end
            if (vram_we && vram_ready) begin
                ram[vram_addr] = vram_data;
                writeCount++;
            end
            if (done) doneCount++;
            prevWe    = vram_we;
            prevReady = vram_ready;
            prevAddr  = vram_addr;
            prevData  = vram_data;
            prevValid = 1'b1;
        end
    end

    // Blink instance: toggle after every 8th edge, colon write completes two edges later.
    always @(posedge clk) begin
        if (rst2) edge2 = 0;
        else edge2++;
    end

    always @(negedge clk) begin
        int te;
        int m;
        if (!rst2 && we2 && ready2) begin
            te = edge2 + 1;
            if (te >= 24 && te < 88) begin
                m = (te - 2) / 8;
                colonWrites2++;
                checkOutput("blink_addr", 32'(addr2), 32'd2);
                checkOutput("blink_phase", 32'((te - 2) % 8), 32'd0);
                checkOutput("blink_data", 32'(data2), (m % 2 == 1) ? 32'h20 : 32'h3A);
            end
        end
    end

    initial begin
        rst2   = 1'b1;
        ascii2 = 32'h31323334;
        ready2 = 1'b1;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
    end

    initial begin
        logic [31:0] word;
        int w0;
        int d0;
        rst        = 1'b1;
        ascii      = 32'h31323334;
        vram_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_we", 32'(vram_we), 32'd0);
        checkOutput("reset_addr", 32'(vram_addr), 32'(BASE));
        checkOutput("reset_data", 32'(vram_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);

        // First sequence after reset uses the zero snapshot, a second one follows with the input.
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("first_we", 32'(vram_we), 32'd1);
        checkOutput("first_addr", 32'(vram_addr), 32'(BASE));
        checkOutput("first_data", 32'(vram_data), 32'h3F);
        settle("boot");
        checkDisplay("boot", 32'h31323334);

        w0 = writeCount;
        d0 = doneCount;
        applyStimulus(32'h31323335);
        tick();
        checkOutput("lat_n", 32'(vram_we), 32'd0);
        tick();
        checkOutput("lat_n1", 32'(vram_we), 32'd0);
        tick();
        checkOutput("lat_n2_we", 32'(vram_we), 32'd1);
        checkOutput("lat_n2_addr", 32'(vram_addr), 32'(BASE));
        settle("lat");
        checkOutput("lat_min1", 32'(ram[BASE + 4]), 32'h35);
        checkOutput("lat_writes", 32'(writeCount - w0), 32'd5);
        checkOutput("lat_dones", 32'(doneCount - d0), 32'd1);

        applyStimulus(32'h3132413A);
        settle("bad");
        checkDisplay("bad", 32'h3132413A);

        applyStimulus(32'h32333435);
        waitAddr(1, "stall");
        vram_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("stall_we", 32'(vram_we), 32'd1);
            checkOutput("stall_addr", 32'(vram_addr), 32'(BASE + 1));
            checkOutput("stall_data", 32'(vram_data), 32'h33);
        end
        vram_ready = 1'b1;
        tick();
        checkOutput("stall_advance", 32'(vram_addr), 32'(BASE + 2));
        settle("stall");
        checkDisplay("stall", 32'h32333435);

        applyStimulus(32'h31353039);
        waitAddr(2, "rstmid");
        vram_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rstmid_we", 32'(vram_we), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_addr", 32'(vram_addr), 32'(BASE));
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        vram_ready = 1'b1;
        tick();
        checkOutput("restart_we", 32'(vram_we), 32'd1);
        checkOutput("restart_addr", 32'(vram_addr), 32'(BASE));
        checkOutput("restart_data", 32'(vram_data), 32'h3F);
        settle("restart");
        checkDisplay("restart", 32'h31353039);

        randomReady = 1'b1;
        for (int it = 0; it < 20; it++) begin
            do begin
                word = {randChar(), randChar(), randChar(), randChar()};
            end while (word == ascii);
            w0 = writeCount;
            d0 = doneCount;
            applyStimulus(word);
            settle($sformatf("rand%0d", it));
            checkDisplay($sformatf("rand%0d", it), word);
            checkOutput($sformatf("rand%0d_writes", it), 32'(writeCount - w0), 32'd5);
            checkOutput($sformatf("rand%0d_dones", it), 32'(doneCount - d0), 32'd1);
        end
        randomReady = 1'b0;
        vram_ready  = 1'b1;

        checkOutput("blink_count", 32'(colonWrites2), 32'd8);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
